// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter, its receiver and benches.
// Holds the FSM state encoding, the line levels for each bit role, and a
// helper that gives the frame length in cycles for a given data width.
package serial_frame_tx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;
   localparam state_t ST_GAP    = 3'd5;

   localparam logic START_LVL = 1'b1;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b0;

   // start + data + parity + stop
   function automatic int frame_len(input int bit_len);
      return bit_len + 3;
   endfunction

endpackage

// File: rtl/serial_frame_tx_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rstn        clock, async active-low reset (pointers/count cleared)
//   push_i, wdata_i  write request and data; ignored while full
//   pop_i, rdata_o   read request and head-of-queue data; ignored while empty
//   full_o, empty_o  derived from the registered count
//   level_o          current occupancy
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: buffers parallel words and serializes each one as
// start(1), data LSB-first, parity, stop(1), followed by GAP low cycles.
// Ports:
//   clk, rstn     clock, async active-low reset (line drops to 0 at once)
//   data_in       word to send
//   in_valid      data_in valid; accepted when in_ready is high
//   in_ready      FIFO not full (from registered count)
//   inject_perr   sampled at pop; inverts that frame's parity bit
//   channel_out   registered serial line, idle low
//   busy          high from the start-bit cycle through the last gap cycle
//   frame_done    one-cycle pulse during the stop bit
//   fifo_level    FIFO occupancy
module serial_frame_tx
   import serial_frame_tx_pkg::*;
#(
   parameter int BIT_LEN = 7,
   parameter int DEPTH   = 4,
   parameter int GAP     = 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [BIT_LEN-1:0]     data_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   inject_perr,
   output logic                   channel_out,
   output logic                   busy,
   output logic                   frame_done,
   output logic [$clog2(DEPTH):0] fifo_level
);

   // One counter serves both the data-bit index and the gap countdown.
   localparam int CNT_MAX = (BIT_LEN > GAP) ? BIT_LEN : GAP;
   localparam int IDX_W   = $clog2(CNT_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(BIT_LEN - 1);
   localparam logic [IDX_W-1:0] LAST_GAP = IDX_W'(GAP - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BIT_LEN-1:0]   shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 chan_q, chan_d;
   logic                 busy_q, busy_d;
   logic                 fdone_q, fdone_d;
   logic                 load;
   logic                 fifo_full, fifo_empty;
   logic [BIT_LEN-1:0]   fifo_rdata;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BIT_LEN)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (in_valid),
      .wdata_i (data_in),
      .pop_i   (load),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign in_ready    = !fifo_full;
   assign channel_out = chan_q;
   assign busy        = busy_q;
   assign frame_done  = fdone_q;

   // Each state's line level is registered on the edge that enters it, so
   // the value driven here is what the wire shows during the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      chan_d  = chan_q;
      busy_d  = busy_q;
      fdone_d = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            chan_d = IDLE_LVL;
            busy_d = 1'b0;
            load   = !fifo_empty;
         end
         ST_START: begin
            chan_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (idx_q == LAST_BIT) begin
               chan_d  = par_q;
               state_d = ST_PARITY;
            end else begin
               chan_d  = shreg_q[0];
               shreg_d = shreg_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_PARITY: begin
            chan_d  = STOP_LVL;
            fdone_d = 1'b1;
            state_d = ST_STOP;
         end
         ST_STOP: begin
            chan_d  = IDLE_LVL;
            idx_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (idx_q == LAST_GAP) begin
               // Chain straight into the next frame when work is queued.
               if (fifo_empty) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  load = 1'b1;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            chan_d  = IDLE_LVL;
            busy_d  = 1'b0;
         end
      endcase
      // Pop: capture the word so later pushes cannot disturb the frame.
      if (load) begin
         shreg_d = fifo_rdata;
         par_d   = (^fifo_rdata) ^ inject_perr;
         chan_d  = START_LVL;
         busy_d  = 1'b1;
         state_d = ST_START;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         chan_q  <= IDLE_LVL;
         busy_q  <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         chan_q  <= chan_d;
         busy_q  <= busy_d;
         fdone_q <= fdone_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table-driven single frames, a full-FIFO burst,
// a mid-frame reset and a long random run, all under a per-cycle reference.
module tb_serial_frame_tx;
   import serial_frame_tx_pkg::*;

   localparam int BL  = 7;
   localparam int DP  = 4;
   localparam int GP  = 2;
   localparam int FL  = frame_len(BL);
   localparam int PER = FL + GP;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [BL-1:0] data_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          inject_perr = 1'b0;
   logic          channel_out;
   logic          busy;
   logic          frame_done;
   logic [2:0]    fifo_level;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   serial_frame_tx #(.BIT_LEN(BL), .DEPTH(DP), .GAP(GP)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .data_in     (data_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .inject_perr (inject_perr),
      .channel_out (channel_out),
      .busy        (busy),
      .frame_done  (frame_done),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: a queue of words plus the edge of the last pop. A pop is
   // allowed once PER cycles have passed since the previous one; the line
   // is then a pure function of the cycle offset from that pop.
   int            cyc = 0;
   int            free_at = 0;
   int            pop_at = -1000;
   int            mlevel = 0;
   int            m_pops = 0;
   bit            m_pushed = 0;
   logic [BL-1:0] cur_w = '0;
   logic          cur_p = 1'b0;
   logic [BL-1:0] mq[$];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mq.delete();
         mlevel   = 0;
         free_at  = 0;
         pop_at   = -1000;
         m_pushed = 0;
      end else begin
         bit do_pop, do_push;
         cyc++;
         do_pop  = (mlevel > 0) && (cyc >= free_at);
         do_push = in_valid && (mlevel < DP);
         if (do_pop) begin
            cur_w   = mq.pop_front();
            cur_p   = (^cur_w) ^ inject_perr;
            pop_at  = cyc;
            free_at = cyc + PER;
            m_pops++;
         end
         if (do_push) mq.push_back(data_in);
         mlevel   = mlevel + int'(do_push) - int'(do_pop);
         m_pushed = do_push;
      end
   end

   always @(negedge clk) begin
      if (rstn && chk_on) begin
         int   k;
         logic el;
         k  = cyc - pop_at;
         el = 1'b0;
         if (k == 0) el = 1'b1;
         else if (k >= 1 && k <= BL) el = cur_w[k-1];
         else if (k == BL + 1) el = cur_p;
         else if (k == BL + 2) el = 1'b1;
         check("cycle{line,busy,fdone,rdy,lvl}",
               {25'd0, channel_out, busy, frame_done, in_ready, fifo_level},
               {25'd0, el, 1'(cyc < free_at), 1'(k == BL + 2), 1'(mlevel < DP), 3'(mlevel)});
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (mlevel == 0 && cyc >= free_at) return;
         @(negedge clk);
      end
      check("idle_wait_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [BL-1:0] data;
      logic          inj;
      logic          par;
      logic          ok;
   } vec_t;

   vec_t          vecs[6];
   logic [BL-1:0] words[6];
   logic [12:0]   line_v, fd_v;
   int            bcnt, idx, target;

   initial begin
      vecs[0] = '{7'h55, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{7'h01, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{7'h01, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{7'h7F, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{7'h00, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{7'h3C, 1'b1, 1'b1, 1'b0};
      words   = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_line",  32'(channel_out), 32'd0);
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_fdone", 32'(frame_done),  32'd0);
      check("rst_level", 32'(fifo_level),  32'd0);
      check("rst_ready", 32'(in_ready),    32'd1);
      #2 rstn = 1'b1;
      chk_on = 1'b1;

      // Single frames: line pattern, parity, frame_done slot, busy length
      foreach (vecs[v]) begin
         wait_idle();
         inject_perr = vecs[v].inj;
         data_in     = vecs[v].data;
         in_valid    = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         bcnt = 0;
         for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            line_v[i] = channel_out;
            fd_v[i]   = frame_done;
            bcnt += int'(busy);
         end
         inject_perr = 1'b0;
         check("frame_bits", 32'(line_v), 32'({3'b000, 1'b1, vecs[v].par, vecs[v].data, 1'b1}));
         check("frame_done_slot", 32'(fd_v), 32'h200);
         check("busy_cycles", 32'(bcnt), 32'd12);
         check("rx_valid", 32'(line_v[9] == 1'b1 && line_v[8] == ^line_v[7:1]), 32'(vecs[v].ok));
      end

      // Burst of 6 words into a 4-deep FIFO while the first is in flight
      wait_idle();
      idx = 0;
      in_valid = 1'b1;
      data_in  = words[0];
      for (int e = 0; e < 80; e++) begin
         @(negedge clk);
         if (m_pushed) idx++;
         if (e == 4)  begin check("burst_full_lvl", 32'(fifo_level), 32'd4); check("burst_full_rdy", 32'(in_ready), 32'd0); end
         if (e == 12) begin check("full_hold_lvl",  32'(fifo_level), 32'd4); check("full_hold_rdy",  32'(in_ready), 32'd0); end
         if (e == 13) begin check("full_pop_lvl",   32'(fifo_level), 32'd3); check("full_pop_rdy",   32'(in_ready), 32'd1); end
         if (idx < 6) data_in = words[idx];
         else in_valid = 1'b0;
      end
      check("burst_accepted", 32'(idx), 32'd6);
      in_valid = 1'b0;
      wait_idle();

      // Reset during DATA of frame 1 with two words queued
      in_valid = 1'b1; data_in = 7'h7F;
      @(negedge clk); data_in = 7'h12;
      @(negedge clk); data_in = 7'h34;
      @(negedge clk); in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_line",  32'(channel_out), 32'd1);
      check("pre_rst_level", 32'(fifo_level),  32'd2);
      #2 rstn = 1'b0;
      #1;
      check("midrst_line",  32'(channel_out), 32'd0);
      check("midrst_level", 32'(fifo_level),  32'd0);
      check("midrst_busy",  32'(busy),        32'd0);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
      bcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bcnt += int'(channel_out);
      end
      check("post_rst_quiet", 32'(bcnt), 32'd0);

      // Random traffic, 200 frames
      target = m_pops + 200;
      for (int i = 0; i < 6000 && m_pops < target; i++) begin
         @(negedge clk);
         in_valid    = ($urandom_range(0, 3) != 0);
         data_in     = BL'($urandom);
         inject_perr = ($urandom_range(0, 7) == 0);
      end
      check("rand_frames", 32'(m_pops >= target), 32'd1);
      in_valid    = 1'b0;
      inject_perr = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
